// File: rtl/queue_pkg.sv
// Shared helpers for multiport_queue: default sizes, lane-count width
// and leading-ones count used by the lane selectors.
package queue_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    function automatic int lane_cnt_w(input int ports);
        return $clog2(ports + 1);
    endfunction

    // Length of the unbroken run of ones starting at bit 0, capped at n.
    function automatic int lead_ones(input logic [31:0] v, input int n);
        int  k;
        logic run;
        k   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < n && run && v[i]) k = k + 1;
            else                      run = 1'b0;
        end
        return k;
    endfunction

endpackage

// File: rtl/queue_lane_select.sv
// Turns a prefix-contiguous lane request into an accepted-lane count
// and ack mask, clipped to the number of lanes the queue can serve.
module queue_lane_select
    import queue_pkg::*;
#(
    parameter int PORTS     = 2,
    parameter int CNT_WIDTH = 5,
    parameter int LW        = lane_cnt_w(PORTS)
) (
    input  logic [PORTS-1:0]     req_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic [LW-1:0]        n_accepted_o,
    output logic [PORTS-1:0]     ack_o
);

    int lead;
    int lim;
    int n;

    always_comb begin
        lead = lead_ones(32'(req_i), PORTS);
        lim  = int'(limit_i);
        n    = (lead < lim) ? lead : lim;
        n_accepted_o = LW'(n);
        for (int i = 0; i < PORTS; i++) begin
            ack_o[i] = (i < n);
        end
    end

endmodule

// File: rtl/multiport_queue.sv
// Multi-lane circular FIFO with flush and an index probe port.
// Define MULTIPORT_QUEUE_HIGHWATER_EN to add the highWater_OUT tracker.
module multiport_queue
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PORTS      = 2,
    localparam int CNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_IN,
    input  logic [PORTS-1:0]            pushReq_IN,
    input  logic [PORTS*DATA_WIDTH-1:0] data_IN,
    output logic [PORTS-1:0]            pushAck_OUT,
    input  logic [PORTS-1:0]            popReq_IN,
    output logic [PORTS*DATA_WIDTH-1:0] data_OUT,
    output logic [PORTS-1:0]            popValid_OUT,
    output logic [PORTS-1:0]            popAck_OUT,
    output logic [CNT_WIDTH-1:0]        count_OUT,
    output logic                        emptyFlag_OUT,
    output logic                        fullFlag_OUT,
    output logic [ADDR_WIDTH-1:0]       curHead_OUT,
    output logic [ADDR_WIDTH-1:0]       curTail_OUT,
    input  logic [ADDR_WIDTH-1:0]       probeIdx_IN,
    output logic [DATA_WIDTH-1:0]       probeData_OUT,
    input  logic                        probePushReq_IN,
    input  logic [DATA_WIDTH-1:0]       probeData_IN
`ifdef MULTIPORT_QUEUE_HIGHWATER_EN
    ,
    output logic [CNT_WIDTH-1:0]        highWater_OUT
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = lane_cnt_w(PORTS);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic [CNT_WIDTH-1:0]  push_lim;
    logic [LW-1:0]         n_push, n_pop;
    logic [PORTS-1:0]      push_ack, pop_ack;
    logic                  kill;

    // Pops never see same-cycle pushes, pushes never see same-cycle pops.
    assign push_lim = CNT_WIDTH'(DEPTH) - count_q;
    assign kill     = flush_IN | reset;

    queue_lane_select #(
        .PORTS     (PORTS),
        .CNT_WIDTH (CNT_WIDTH),
        .LW        (LW)
    ) u_push_sel (
        .req_i        (pushReq_IN),
        .limit_i      (push_lim),
        .n_accepted_o (n_push),
        .ack_o        (push_ack)
    );

    queue_lane_select #(
        .PORTS     (PORTS),
        .CNT_WIDTH (CNT_WIDTH),
        .LW        (LW)
    ) u_pop_sel (
        .req_i        (popReq_IN),
        .limit_i      (count_q),
        .n_accepted_o (n_pop),
        .ack_o        (pop_ack)
    );

    assign pushAck_OUT = push_ack & {PORTS{~kill}};
    assign popAck_OUT  = pop_ack & {PORTS{~kill}};

    always_comb begin
        count_d = count_q + CNT_WIDTH'(n_push) - CNT_WIDTH'(n_pop);
        head_d  = head_q + ADDR_WIDTH'(n_pop);
        tail_d  = tail_q + ADDR_WIDTH'(n_push);
        if (flush_IN) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Probe write is issued last so it overrides a push to the same slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (pushAck_OUT[i]) begin
                mem_q[tail_q + ADDR_WIDTH'(i)] <=
                    data_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (probePushReq_IN) begin
            mem_q[probeIdx_IN] <= probeData_IN;
        end
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_lane
        assign data_OUT[g*DATA_WIDTH +: DATA_WIDTH] =
            mem_q[head_q + ADDR_WIDTH'(g)];
        assign popValid_OUT[g] = (count_q > CNT_WIDTH'(g));
    end

    assign count_OUT     = count_q;
    assign emptyFlag_OUT = (count_q == '0);
    assign fullFlag_OUT  = (count_q == CNT_WIDTH'(DEPTH));
    assign curHead_OUT   = head_q;
    assign curTail_OUT   = tail_q;
    assign probeData_OUT = mem_q[probeIdx_IN];

`ifdef MULTIPORT_QUEUE_HIGHWATER_EN
    logic [CNT_WIDTH-1:0] hw_q, hw_d;

    always_comb begin
        hw_d = (count_d > hw_q) ? count_d : hw_q;
        if (flush_IN) hw_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hw_q <= '0;
        else       hw_q <= hw_d;
    end

    assign highWater_OUT = hw_q;
`endif

endmodule
